operand_fetch_seq: RTL and testbench
====================================

Name: operand_fetch_seq

Overview:
- Sequencer directly upstream of the 8x16 register file.
- Accepts a decoded instruction (rn, rm, rd, op) and drives the register file's single read port over successive cycles.
- Captures operands A and B, then presents them to the ALU stage with a valid/ready handshake.
- Also routes write-back requests onto the register file write port, with an optional same-cycle forwarding path.

Parameters:
- WIDTH, 16, register and operand width; must match the register file data width.
- OPW, 2, width of the pass-through op field.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction request valid
- in_ready  out  1  sequencer can accept a request
- in_rn  in  3  register index for operand A
- in_rm  in  3  register index for operand B
- in_rd  in  3  destination index, passed through
- in_op  in  OPW  op field, passed through
- in_one_op  in  1  instruction uses A only; skip the B read
- readnum  out  3  register file read index
- rf_data  in  WIDTH  register file read data (combinational from readnum)
- wb_valid  in  1  write-back request
- wb_num  in  3  write-back register index
- wb_data  in  WIDTH  write-back data
- write  out  1  register file write enable
- writenum  out  3  register file write index
- data_in  out  WIDTH  register file write data
- out_valid  out  1  operands valid toward the ALU
- out_ready  in  1  ALU accepts operands
- out_a  out  WIDTH  captured operand A
- out_b  out  WIDTH  captured operand B (0 when one-op)
- out_rd  out  3  latched rd
- out_op  out  OPW  latched op

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: state=IDLE; out_valid=0; out_a=0; out_b=0; out_rd=0; out_op=0; latched rn/rm/one_op=0.
- Write-back path: purely combinational.
  - write = wb_valid, writenum = wb_num, data_in = wb_data.
  - Independent of state and never stalled; write-back takes effect at the next clk edge inside the register file.
- FSM states: IDLE, READ_A, READ_B, HOLD.
- IDLE:
  - in_ready=1, readnum=0, out_valid=0.
  - in_valid=1 at an edge: latch rn, rm, rd, op, one_op; go to READ_A.
- READ_A:
  - in_ready=0, readnum=latched rn.
  - At the edge, out_a<=rf_data.
  - Next state: one_op ? HOLD with out_b<=0 : READ_B.
- READ_B:
  - in_ready=0, readnum=latched rm.
  - At the edge, out_b<=rf_data; go to HOLD.
- HOLD:
  - out_valid=1, readnum=0, in_ready=0.
  - out_a, out_b, out_rd and out_op are held stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready at an edge: return to IDLE with out_valid=0.
  - No back-to-back acceptance: a new request may be taken in the cycle after the handshake.
- Latency:
  - Two-operand: accept edge, then out_valid=1 after 2 further edges; throughput is 1 instruction per 4 cycles minimum.
  - One-op: out_valid after 1 further edge; 3 cycles minimum.
- Register-file timing: the register file read is combinational and its write is edge-triggered. Without forwarding, a read of register X in the same cycle as wb_num=X captures the OLD value.
- Reset mid-operation: the in-flight instruction is dropped; return to IDLE with out_valid=0 immediately (asynchronous). The combinational write port follows wb_* regardless of reset.
- in_valid in non-IDLE states is ignored; the requester must hold it until in_ready.
- rn==rm is legal: read twice, yielding identical A and B unless a write-back intervenes between the two reads.

Optional Feature:
- Macro: OPERAND_FWD_EN.
- When defined:
  - In READ_A and READ_B, if wb_valid=1 and wb_num equals the index being read, the captured value is wb_data instead of rf_data (same-cycle bypass).
  - In HOLD, if wb_valid=1 and wb_num matches latched rn, out_a<=wb_data at the edge; likewise for rm and out_b (unless one_op).
  - This update occurs even while out_valid is asserted.
- When undefined: no bypass; the old-value behaviour above holds, and HOLD contents never change.

Test Plan:
- Reset; preload R2=0x1234, R5=0x00FF via wb_*; request rn=2, rm=5, rd=7, op=1 -> out_valid 3 cycles after accept with out_a=0x1234, out_b=0x00FF, out_rd=7, out_op=1.
- One-op: rn=5, in_one_op=1 -> out_valid 2 cycles after accept with out_a=0x00FF, out_b=0.
- Back-pressure: hold out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0 throughout; out_ready=1 -> next cycle IDLE with in_ready=1.
- Hazard: during READ_A of rn=2, wb_valid=1, wb_num=2, wb_data=0xBEEF -> out_a=0x1234 without OPERAND_FWD_EN and 0xBEEF with it; after the edge, R2 reads 0xBEEF in both builds.
- Reset asserted while in READ_B -> out_valid=0, in_ready=1 immediately; the next request completes normally.
- rn=rm=3 with R3=0xA5A5 -> out_a=out_b=0xA5A5; a request while in HOLD is ignored until the handshake completes.

Source files
------------

// File: rtl/operand_fetch_seq_if.sv
// Bundle of request, register-file, write-back and ALU-side signals for operand_fetch_seq.
// slave = sequencer view, master = requester/register-file/ALU environment view.
interface operand_fetch_seq_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_rn;
  logic [2:0]       in_rm;
  logic [2:0]       in_rd;
  logic [OPW-1:0]   in_op;
  logic             in_one_op;

  logic [2:0]       readnum;
  logic [WIDTH-1:0] rf_data;

  logic             wb_valid;
  logic [2:0]       wb_num;
  logic [WIDTH-1:0] wb_data;
  logic             write;
  logic [2:0]       writenum;
  logic [WIDTH-1:0] data_in;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [2:0]       out_rd;
  logic [OPW-1:0]   out_op;

  modport slave (
    input  in_valid, in_rn, in_rm, in_rd, in_op, in_one_op,
    input  rf_data,
    input  wb_valid, wb_num, wb_data,
    input  out_ready,
    output in_ready, readnum,
    output write, writenum, data_in,
    output out_valid, out_a, out_b, out_rd, out_op
  );

  modport master (
    output in_valid, in_rn, in_rm, in_rd, in_op, in_one_op,
    output rf_data,
    output wb_valid, wb_num, wb_data,
    output out_ready,
    input  in_ready, readnum,
    input  write, writenum, data_in,
    input  out_valid, out_a, out_b, out_rd, out_op
  );
endinterface

// File: rtl/operand_fetch_seq.sv
// Operand fetch sequencer: reads A then B through the single register-file read port and
// hands them to the ALU; `define OPERAND_FWD_EN enables the same-cycle write-back bypass.
//
// state  | meaning
// IDLE   | ready for a new instruction, read port parked at R0
// READ_A | reading latched rn, capture into out_a
// READ_B | reading latched rm, capture into out_b
// HOLD   | operands valid toward ALU, waiting for out_ready
module operand_fetch_seq #(
  parameter int WIDTH = 16,
  parameter int OPW   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  operand_fetch_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    HOLD   = 2'd3
  } state_t;

`ifdef OPERAND_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       rd_q, rd_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [2:0]       rn_q, rn_d;
  logic [2:0]       rm_q, rm_d;
  logic             one_q, one_d;

  logic             hit_rn;
  logic             hit_rm;
  logic             in_ready;
  logic             out_valid;
  logic [2:0]       readnum;

  // Write-back goes straight to the register file, independent of state and reset.
  assign bus.write    = bus.wb_valid;
  assign bus.writenum = bus.wb_num;
  assign bus.data_in  = bus.wb_data;

  assign hit_rn = FWD_EN && bus.wb_valid && (bus.wb_num == rn_q);
  assign hit_rm = FWD_EN && bus.wb_valid && (bus.wb_num == rm_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      op_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      one_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      op_q    <= op_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      one_q   <= one_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    op_d      = op_q;
    rn_d      = rn_q;
    rm_d      = rm_q;
    one_d     = one_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    readnum   = 3'd0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          rn_d    = bus.in_rn;
          rm_d    = bus.in_rm;
          rd_d    = bus.in_rd;
          op_d    = bus.in_op;
          one_d   = bus.in_one_op;
          state_d = READ_A;
        end
      end

      READ_A: begin
        readnum = rn_q;
        a_d     = hit_rn ? bus.wb_data : bus.rf_data;
        if (one_q) begin
          b_d     = '0;
          state_d = HOLD;
        end else begin
          state_d = READ_B;
        end
      end

      READ_B: begin
        readnum = rm_q;
        b_d     = hit_rm ? bus.wb_data : bus.rf_data;
        state_d = HOLD;
      end

      HOLD: begin
        out_valid = 1'b1;
        // Forwarded updates keep held operands coherent with the register file.
        if (hit_rn) a_d = bus.wb_data;
        if (hit_rm && !one_q) b_d = bus.wb_data;
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.readnum   = readnum;
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_op    = op_q;

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Self-checking bench for operand_fetch_seq with a behavioural register-file model.
module tb_operand_fetch_seq;
  localparam int WIDTH = 16;
  localparam int OPW   = 2;
`ifdef OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  operand_fetch_seq_if #(.WIDTH(WIDTH), .OPW(OPW)) bus();
  operand_fetch_seq #(.WIDTH(WIDTH), .OPW(OPW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Register file driven by the DUT's write port; ref_rf tracks what the bench intended to write.
  logic [WIDTH-1:0] rf     [8];
  logic [WIDTH-1:0] ref_rf [8];
  assign bus.rf_data = rf[bus.readnum];
  always @(posedge clk) if (bus.write) rf[bus.writenum] <= bus.data_in;

  task automatic cyc(input bit v, input logic [2:0] n, input logic [WIDTH-1:0] d);
    bus.wb_valid = v; bus.wb_num = n; bus.wb_data = d;
    @(posedge clk);
    if (v) ref_rf[n] = d;
    @(negedge clk);
    bus.wb_valid = 1'b0;
  endtask

  task automatic do_txn(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                        input logic [OPW-1:0] op, input bit one, input int hold, input bit rnd_wb,
                        input bit haz, input logic [2:0] hn, input logic [WIDTH-1:0] hd,
                        output logic [WIDTH-1:0] oa, output logic [WIDTH-1:0] ob);
    logic [WIDTH-1:0] ea, eb, d;
    logic [2:0] n;
    bit v;
    oa = '0; ob = '0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL idle_before: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    bus.in_valid = 1'b1; bus.in_rn = rn; bus.in_rm = rm; bus.in_rd = rd; bus.in_op = op; bus.in_one_op = one;
    v = rnd_wb && ($urandom_range(0, 1) == 1); n = 3'($urandom_range(0, 7)); d = WIDTH'($urandom);
    cyc(v, n, d);
    bus.in_valid = 1'b0;
    bus.in_rn = 3'($urandom); bus.in_rm = 3'($urandom); bus.in_rd = 3'($urandom);
    bus.in_op = OPW'($urandom); bus.in_one_op = 1'($urandom);
    // READ_A
    total++;
    if (bus.readnum !== rn || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL read_a: readnum=%0d in_ready=%b out_valid=%b want %0d/0/0",
                      bus.readnum, bus.in_ready, bus.out_valid, rn);
    end
    if (haz) begin v = 1'b1; n = hn; d = hd; end
    else begin v = rnd_wb && ($urandom_range(0, 1) == 1); n = 3'($urandom_range(0, 7)); d = WIDTH'($urandom); end
    ea = (FWD && v && n == rn) ? d : ref_rf[rn];
    cyc(v, n, d);
    if (!one) begin
      total++;
      if (bus.readnum !== rm || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        bad++; $display("FAIL read_b: readnum=%0d in_ready=%b out_valid=%b want %0d/0/0",
                        bus.readnum, bus.in_ready, bus.out_valid, rm);
      end
      v = rnd_wb && ($urandom_range(0, 1) == 1); n = 3'($urandom_range(0, 7)); d = WIDTH'($urandom);
      eb = (FWD && v && n == rm) ? d : ref_rf[rm];
      cyc(v, n, d);
    end else begin
      eb = '0;
    end
    for (int h = 0; h <= hold; h++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.readnum !== 3'd0) begin
        bad++; $display("FAIL hold_ctl[%0d]: out_valid=%b in_ready=%b readnum=%0d want 1/0/0",
                        h, bus.out_valid, bus.in_ready, bus.readnum);
      end
      total++;
      if (bus.out_a !== ea || bus.out_b !== eb || bus.out_rd !== rd || bus.out_op !== op) begin
        bad++; $display("FAIL hold_data[%0d]: a=%h b=%h rd=%0d op=%0d want %h %h %0d %0d",
                        h, bus.out_a, bus.out_b, bus.out_rd, bus.out_op, ea, eb, rd, op);
      end
      if (h == 0) begin oa = bus.out_a; ob = bus.out_b; end
      bus.in_valid = 1'($urandom);
      bus.out_ready = (h == hold);
      v = rnd_wb && ($urandom_range(0, 1) == 1); n = 3'($urandom_range(0, 7)); d = WIDTH'($urandom);
      if (FWD && v) begin
        if (n == rn) ea = d;
        if (!one && n == rm) eb = d;
      end
      cyc(v, n, d);
    end
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.readnum !== 3'd0) begin
      bad++; $display("FAIL idle_after: in_ready=%b out_valid=%b readnum=%0d want 1/0/0",
                      bus.in_ready, bus.out_valid, bus.readnum);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.in_valid = 0; bus.in_rn = 0; bus.in_rm = 0; bus.in_rd = 0; bus.in_op = 0; bus.in_one_op = 0;
    bus.wb_valid = 0; bus.wb_num = 0; bus.wb_data = 0; bus.out_ready = 0;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.readnum !== 3'd0) begin
      bad++; $display("FAIL reset_ctl: out_valid=%b in_ready=%b readnum=%0d want 0/1/0",
                      bus.out_valid, bus.in_ready, bus.readnum);
    end
    total++;
    if (bus.out_a !== '0 || bus.out_b !== '0 || bus.out_rd !== 3'd0 || bus.out_op !== '0) begin
      bad++; $display("FAIL reset_data: a=%h b=%h rd=%0d op=%0d want all 0",
                      bus.out_a, bus.out_b, bus.out_rd, bus.out_op);
    end
    reset_n = 1'b1;
    cyc(1'b0, 3'd0, '0);
  endtask

  task automatic test_writeback();
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 11; i++) begin
      logic [2:0] n;
      n = (i < 8) ? 3'(i) : (i == 8) ? 3'd2 : (i == 9) ? 3'd5 : 3'd3;
      d = (i < 8) ? WIDTH'($urandom) : (i == 8) ? 16'h1234 : (i == 9) ? 16'h00FF : 16'hA5A5;
      bus.wb_valid = 1'b1; bus.wb_num = n; bus.wb_data = d;
      #1;
      total++;
      if (bus.write !== 1'b1 || bus.writenum !== n || bus.data_in !== d) begin
        bad++; $display("FAIL wb_port: write=%b num=%0d data=%h want 1 %0d %h",
                        bus.write, bus.writenum, bus.data_in, n, d);
      end
      cyc(1'b1, n, d);
    end
    total++;
    if (bus.write !== 1'b0) begin
      bad++; $display("FAIL wb_idle: write=%b want 0", bus.write);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] oa, ob;
    do_txn(3'd2, 3'd5, 3'd7, 2'd1, 1'b0, 0, 1'b0, 1'b0, 3'd0, '0, oa, ob);
    total++;
    if (oa !== 16'h1234 || ob !== 16'h00FF) begin
      bad++; $display("FAIL basic: a=%h b=%h want 1234 00ff", oa, ob);
    end
  endtask

  task automatic test_one_op();
    logic [WIDTH-1:0] oa, ob;
    do_txn(3'd5, 3'd6, 3'd1, 2'd2, 1'b1, 0, 1'b0, 1'b0, 3'd0, '0, oa, ob);
    total++;
    if (oa !== 16'h00FF || ob !== 16'h0000) begin
      bad++; $display("FAIL one_op: a=%h b=%h want 00ff 0000", oa, ob);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] oa, ob;
    do_txn(3'd5, 3'd2, 3'd4, 2'd3, 1'b0, 5, 1'b0, 1'b0, 3'd0, '0, oa, ob);
    total++;
    if (oa !== 16'h00FF || ob !== 16'h1234) begin
      bad++; $display("FAIL backpressure: a=%h b=%h want 00ff 1234", oa, ob);
    end
  endtask

  task automatic test_hazard();
    logic [WIDTH-1:0] oa, ob, want;
    want = FWD ? 16'hBEEF : 16'h1234;
    do_txn(3'd2, 3'd5, 3'd0, 2'd0, 1'b0, 1, 1'b0, 1'b1, 3'd2, 16'hBEEF, oa, ob);
    total++;
    if (oa !== want) begin
      bad++; $display("FAIL hazard_a: a=%h want %h", oa, want);
    end
    do_txn(3'd2, 3'd0, 3'd0, 2'd0, 1'b1, 0, 1'b0, 1'b0, 3'd0, '0, oa, ob);
    total++;
    if (oa !== 16'hBEEF) begin
      bad++; $display("FAIL hazard_after: a=%h want beef", oa);
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] oa, ob;
    bus.in_valid = 1'b1; bus.in_rn = 3'd5; bus.in_rm = 3'd2; bus.in_rd = 3'd6; bus.in_op = 2'd3; bus.in_one_op = 1'b0;
    cyc(1'b0, 3'd0, '0);
    bus.in_valid = 1'b0;
    cyc(1'b0, 3'd0, '0);
    total++;
    if (bus.readnum !== 3'd2) begin
      bad++; $display("FAIL mid_in_read_b: readnum=%0d want 2", bus.readnum);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.readnum !== 3'd0) begin
      bad++; $display("FAIL mid_reset: out_valid=%b in_ready=%b readnum=%0d want 0/1/0",
                      bus.out_valid, bus.in_ready, bus.readnum);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1'b0, 3'd0, '0);
    do_txn(3'd3, 3'd2, 3'd5, 2'd2, 1'b0, 0, 1'b0, 1'b0, 3'd0, '0, oa, ob);
    total++;
    if (oa !== 16'hA5A5 || ob !== 16'hBEEF) begin
      bad++; $display("FAIL after_reset: a=%h b=%h want a5a5 beef", oa, ob);
    end
  endtask

  task automatic test_same_reg();
    logic [WIDTH-1:0] oa, ob;
    do_txn(3'd3, 3'd3, 3'd2, 2'd1, 1'b0, 3, 1'b0, 1'b0, 3'd0, '0, oa, ob);
    total++;
    if (oa !== 16'hA5A5 || ob !== 16'hA5A5) begin
      bad++; $display("FAIL same_reg: a=%h b=%h want a5a5 a5a5", oa, ob);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] oa, ob;
    for (int t = 0; t < 40; t++) begin
      do_txn(3'($urandom), 3'($urandom), 3'($urandom), OPW'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'b1, 1'b0, 3'd0, '0, oa, ob);
    end
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_basic();
    test_one_op();
    test_backpressure();
    test_hazard();
    test_reset_mid();
    test_same_reg();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
